// File: rtl/tinynpu_ostream_drain.sv
// Output-stream drain for TinyNPU: captures SIZE accumulator lanes on request and
// serializes them over a val/rdy stream. Optional ReLU at capture: TINYNPU_OSTREAM_RELU_EN.
module tinynpu_ostream_drain #(
  parameter int SIZE     = 4,
  parameter int ACC_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ostream_req,
  input  logic [SIZE*ACC_BITS-1:0]   ostream_data,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [ACC_BITS-1:0]        out_data,
  output logic [$clog2(SIZE)-1:0]    out_idx,
  output logic                       out_last,
  output logic                       ostream_busy,
  output logic                       ostream_done,
  output logic [7:0]                 frame_cnt,
  output logic                       ovf_err,
  input  logic                       ovf_clr
);

  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                capture;
  logic                handshake;
  logic [IDX_W-1:0]    idx;
  logic [ACC_BITS-1:0] frame_buf [SIZE];

  function automatic logic [ACC_BITS-1:0] lane_in(input logic [ACC_BITS-1:0] v);
`ifdef TINYNPU_OSTREAM_RELU_EN
    return v[ACC_BITS-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign handshake = (state == DRAIN) && out_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A request landing in the DONE cycle starts the next frame directly.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ostream_req) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_rdy && (idx == LAST_IDX)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (ostream_req) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      frame_cnt <= '0;
      ovf_err   <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        frame_buf[i] <= '0;
      end
    end else begin
      if (capture) begin
        idx <= '0;
        for (int i = 0; i < SIZE; i++) begin
          frame_buf[i] <= lane_in(ostream_data[i*ACC_BITS +: ACC_BITS]);
        end
      end else if (handshake && (idx != LAST_IDX)) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == DONE) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      // A dropped request outranks a simultaneous clear.
      if ((state == DRAIN) && ostream_req) begin
        ovf_err <= 1'b1;
      end else if (ovf_clr) begin
        ovf_err <= 1'b0;
      end
    end
  end

  always_comb begin
    out_val      = (state == DRAIN);
    ostream_busy = (state == DRAIN);
    ostream_done = (state == DONE);
    out_idx      = out_val ? idx : '0;
    out_data     = out_val ? frame_buf[idx] : '0;
    out_last     = out_val && (idx == LAST_IDX);
  end

endmodule

// File: doc/tinynpu_ostream_drain.md
Name: tinynpu_ostream_drain

Overview:
- Output-side counterpart of the TinyNPU controller's output-stream request: responds to the controller's single-cycle ostream request by capturing all SIZE MAC accumulator results in parallel.
- Serializes the captured results to the host over a val/rdy stream, one word per handshake.
- Reports completion back to the controller with a done pulse.
- Sits between the MAC array outputs and the host output port, and implements the controller's OUT phase.

Parameters:
- SIZE, 4, number of MAC lanes and words per output frame; power of two, at least 2.
- ACC_BITS, 32, width of each signed two's-complement accumulator result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ostream_req  in  1  single-cycle capture request from the controller.
- ostream_data  in  SIZE*ACC_BITS  MAC results; lane i occupies bits [i*ACC_BITS +: ACC_BITS].
- out_val  out  1  host stream valid.
- out_rdy  in  1  host stream ready.
- out_data  out  ACC_BITS  current word.
- out_idx  out  $clog2(SIZE)  lane index of the current word.
- out_last  out  1  high with the word where out_idx==SIZE-1.
- ostream_busy  out  1  high in DRAIN.
- ostream_done  out  1  one-cycle pulse after the last handshake.
- frame_cnt  out  8  count of completed frames; wraps 255->0.
- ovf_err  out  1  sticky error: a request was dropped.
- ovf_clr  in  1  synchronous clear of ovf_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; idx=0; the buffer is cleared to 0.
  - out_val=0, out_data=0, out_idx=0, out_last=0, ostream_busy=0, ostream_done=0, frame_cnt=0, ovf_err=0.
  - Reset mid-DRAIN aborts the frame. No done pulse is issued and frame_cnt is unchanged.
- State machine: IDLE, DRAIN, DONE.
- IDLE:
  - ostream_req=1: capture all SIZE lanes into the buffer, set idx=0, go to DRAIN.
  - Otherwise stay in IDLE.
- DRAIN:
  - out_val=1, out_data=buf[idx], out_idx=idx, out_last=(idx==SIZE-1).
  - On out_val&out_rdy: if idx==SIZE-1, go to DONE; otherwise idx=idx+1.
  - out_rdy=0 holds all outputs stable. out_data and out_idx must not change while out_val=1 and out_rdy=0.
  - ostream_req=1 in DRAIN is ignored: the buffer is not overwritten and ovf_err is set to 1.
- DONE (exactly one cycle):
  - ostream_done=1; frame_cnt increments by 1.
  - If ostream_req=1 in the same cycle, capture and go to DRAIN. This is not an overflow.
  - Otherwise go to IDLE.
- Latency:
  - Request in cycle N gives out_val=1 in cycle N+1.
  - With out_rdy held at 1, a frame takes SIZE cycles in DRAIN, then 1 cycle in DONE.
  - Request-to-done is SIZE+1 cycles.
- ovf_err:
  - Sets on a dropped request; holds until ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Width rules:
  - idx is $clog2(SIZE) bits and never wraps in DRAIN (the last index exits the state).
  - frame_cnt is modulo 256.
- All outputs are registered or decoded from registered state only. There is no combinational path from ostream_req or out_rdy to out_val or out_data.

Optional Feature:
- Macro TINYNPU_OSTREAM_RELU_EN.
- Defined: at capture, each lane with a negative signed value (MSB=1) is stored as 0; non-negative lanes are stored unchanged. The ReLU is applied before buffering, so the timing is identical to the non-ReLU build.
- Undefined: lanes are stored and emitted bit-exact, with no clamping logic instantiated.

Test Plan:
- Reset mid-DRAIN: rst=0 while idx=2 -> all outputs 0 and state IDLE immediately (asynchronous); no done pulse; frame_cnt unchanged.
- Basic frame, SIZE=4:
  - Stimulus: req with lanes {10, -3, 0x7FFFFFFF, 5}, out_rdy=1.
  - Response: out_data 10, 0xFFFFFFFD, 0x7FFFFFFF, 5 in cycles N+1..N+4; out_idx 0..3; out_last only on word 3.
  - Done pulse at N+5; frame_cnt=1.
  - With TINYNPU_OSTREAM_RELU_EN: the second word is 0.
- Backpressure: out_rdy toggled 1,0,0,1,0,1,1 -> each word is held stable while rdy=0; all 4 words are delivered in order with no duplicates and no loss.
- Overflow: second req while idx=1 -> ovf_err=1; the original frame drains unchanged; ovf_clr=1 clears the flag; set and clear in the same cycle leaves ovf_err=1.
- Back-to-back: req again in the DONE cycle -> done=1 that cycle, out_val=1 next cycle with the new data; ovf_err stays 0.
- Counter wrap: 256 frames -> frame_cnt returns to 0; ostream_done pulses exactly 256 times.
